// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, FSM encoding and instruction field layout shared by the ALU issue unit and the ALU.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package alu_pkg;

    localparam int DATA_W  = 8;
    localparam int REG_AW  = 2;
    localparam int INSTR_W = 16;

    // Opcodes, shared with the combinational ALU
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_LS  = 4'b0011;
    localparam logic [3:0] OP_SRS = 4'b0100;
    localparam logic [3:0] OP_URS = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_RRO = 4'b1000;
    localparam logic [3:0] OP_LRO = 4'b1001;
    localparam logic [3:0] OP_LDI = 4'b1010;

    // Instruction fields: [15:12] op, [11:10] rd, [9:8] rs, [7:0] imm
    localparam int OP_HI  = 15;
    localparam int OP_LO  = 12;
    localparam int RD_HI  = 11;
    localparam int RD_LO  = 10;
    localparam int RS_HI  = 9;
    localparam int RS_LO  = 8;
    localparam int IMM_HI = 7;
    localparam int IMM_LO = 0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_e;

    // Opcodes above LDI are undefined
    function automatic logic op_is_legal(input logic [3:0] op);
        return op <= OP_LDI;
    endfunction

    // Only the add/subtract pair owns the carry and overflow flags
    function automatic logic op_sets_cv(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// alu_regfile: NREG x DW register file behind the ALU issue unit.
// Latency: write lands on the next rising edge; all read ports are combinational.
// Backpressure: none; the write enable is owned by the issue FSM.
// Ports: clk/rst (synchronous clear), we_i/waddr_i/wdata_i write port,
//        raddr_a_i/raddr_b_i -> rdata_a_o/rdata_b_o operand reads, dbg_sel_i -> dbg_data_o debug read.
module alu_regfile #(
    parameter int DW   = 8,
    parameter int NREG = 4,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_a_i,
    output logic [DW-1:0] rdata_a_o,
    input  logic [AW-1:0] raddr_b_i,
    output logic [DW-1:0] rdata_b_o,
    input  logic [AW-1:0] dbg_sel_i,
    output logic [DW-1:0] dbg_data_o
);

    logic [DW-1:0] rf_q [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (we_i) begin
            rf_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o  = rf_q[raddr_a_i];
    assign rdata_b_o  = rf_q[raddr_b_i];
    assign dbg_data_o = rf_q[dbg_sel_i];

endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: accepts 16-bit instructions, feeds the external ALU, writes the result back.
// Latency: done pulses 3 cycles after accept; written register readable 4 cycles after accept.
// Backpressure: in_ready low from accept until back in IDLE; one instruction per 4 cycles.
// Ports: clk/rst, in_valid/in_ready/in_instr instruction handshake, alu_op/alu_a/alu_b to the ALU,
//        alu_y + alu_{cr,ov,ng,zr} from the ALU, done/result/illegal retire status,
//        flags {cr,ov,ng,zr} status, dbg_sel/dbg_data register-file peek.
module alu_issue_ctrl
    import alu_pkg::*;
#(
    parameter int DW   = 8,
    parameter int NREG = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   in_instr,
    output logic [3:0]    alu_op,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    input  logic [DW-1:0] alu_y,
    input  logic          alu_cr,
    input  logic          alu_ov,
    input  logic          alu_ng,
    input  logic          alu_zr,
    output logic          done,
    output logic [DW-1:0] result,
    output logic          illegal,
    output logic [3:0]    flags,
    input  logic [1:0]    dbg_sel,
    output logic [DW-1:0] dbg_data
);

    state_e        state_q, state_d;

    logic [3:0]    alu_op_q;
    logic [DW-1:0] alu_a_q, alu_b_q;
    logic [1:0]    rd_q;
    logic [DW-1:0] imm_q;
    logic [DW-1:0] result_q, result_d;
    logic [3:0]    flags_q, flags_d;
    logic          done_q, illegal_q;

    logic [DW-1:0] rf_a, rf_b;
    logic          accept;
    logic          op_legal;
    logic          rf_we;

    // in_ready is forced low while rst is held so nothing is accepted during reset
    assign in_ready = (state_q == ST_IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign op_legal = op_is_legal(alu_op_q);
    assign rf_we    = (state_q == ST_WB) && op_legal;

    // Operands are read with the incoming rd/rs so alu_* are registered on the
    // accept edge and stay stable from DECODE through WB.
    alu_regfile #(
        .DW   (DW),
        .NREG (NREG)
    ) u_regfile (
        .clk        (clk),
        .rst        (rst),
        .we_i       (rf_we),
        .waddr_i    (rd_q),
        .wdata_i    (result_q),
        .raddr_a_i  (in_instr[RD_HI:RD_LO]),
        .rdata_a_o  (rf_a),
        .raddr_b_i  (in_instr[RS_HI:RS_LO]),
        .rdata_b_o  (rf_b),
        .dbg_sel_i  (dbg_sel),
        .dbg_data_o (dbg_data)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (accept) state_d = ST_DECODE;
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_WB;
            ST_WB:     state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Value and flags captured at the end of EXEC, after the ALU had the whole cycle to settle
    always_comb begin
        result_d = alu_y;
        flags_d  = flags_q;
        if (!op_legal) begin
            result_d = '0;
        end else if (alu_op_q == OP_LDI) begin
            result_d = imm_q;
        end else if (op_sets_cv(alu_op_q)) begin
            flags_d = {alu_cr, alu_ov, alu_ng, alu_zr};
        end else begin
            flags_d = {flags_q[3:2], alu_ng, alu_zr};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op_q  <= OP_AND;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            result_q  <= '0;
            flags_q   <= '0;
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            illegal_q <= 1'b0;
            if (accept) begin
                alu_op_q <= in_instr[OP_HI:OP_LO];
                alu_a_q  <= rf_a;
                alu_b_q  <= rf_b;
                rd_q     <= in_instr[RD_HI:RD_LO];
                imm_q    <= in_instr[IMM_HI:IMM_LO];
            end
            // Loading on EXEC->WB makes done/illegal/result visible exactly during WB
            if (state_q == ST_EXEC) begin
                done_q    <= 1'b1;
                illegal_q <= !op_legal;
                result_q  <= result_d;
                flags_q   <= flags_d;
            end
        end
    end

    assign alu_op  = alu_op_q;
    assign alu_a   = alu_a_q;
    assign alu_b   = alu_b_q;
    assign done    = done_q;
    assign illegal = illegal_q;
    assign result  = result_q;
    assign flags   = flags_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed test-plan steps followed by random instructions,
// checked against a register/flag model of the unit with a behavioural ALU on the far side.
module tb_alu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_instr;
    logic [3:0]  alu_op;
    logic [7:0]  alu_a, alu_b, alu_y;
    logic        alu_cr, alu_ov, alu_ng, alu_zr;
    logic        done, illegal;
    logic [7:0]  result;
    logic [3:0]  flags;
    logic [1:0]  dbg_sel;
    logic [7:0]  dbg_data;

    int vectors     = 0;
    int miscompares = 0;

    logic [7:0] mr [4];
    logic [3:0] mflags;

    always #5 clk = ~clk;

    // Behavioural ALU: returns {cr, ov, ng, zr, y}. Non-arithmetic ops report
    // arbitrary cr/ov and LDI/undefined ops return junk so ignored paths are exercised.
    function automatic logic [11:0] alu_model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [8:0] s;
        logic [7:0] y;
        logic       cr, ov;
        y  = 8'h00;
        cr = a[0];
        ov = b[0];
        s  = 9'h000;
        case (op)
            4'd0: y = a & b;
            4'd1: y = a | b;
            4'd2: begin
                s  = {1'b0, a} + {1'b0, b};
                y  = s[7:0];
                cr = s[8];
                ov = (a[7] == b[7]) && (y[7] != a[7]);
            end
            4'd3: begin y = {a[6:0], 1'b0}; cr = a[7]; ov = a[7] ^ a[6]; end
            4'd4: y = {a[7], a[7:1]};
            4'd5: y = {1'b0, a[7:1]};
            4'd6: begin
                y  = a - b;
                cr = (a < b);
                ov = (a[7] != b[7]) && (y[7] != a[7]);
            end
            4'd7: begin y = ($signed(a) < $signed(b)) ? 8'h01 : 8'h00; cr = 1'b1; ov = 1'b1; end
            4'd8: y = {a[0], a[7:1]};
            4'd9: y = {a[6:0], a[7]};
            default: begin y = 8'hEE; cr = 1'b1; ov = 1'b1; end
        endcase
        return {cr, ov, y[7], (y == 8'h00), y};
    endfunction

    assign {alu_cr, alu_ov, alu_ng, alu_zr, alu_y} = alu_model(alu_op, alu_a, alu_b);

    alu_issue_ctrl #(.DW(8), .NREG(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_instr (in_instr),
        .alu_op   (alu_op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_y    (alu_y),
        .alu_cr   (alu_cr),
        .alu_ov   (alu_ov),
        .alu_ng   (alu_ng),
        .alu_zr   (alu_zr),
        .done     (done),
        .result   (result),
        .illegal  (illegal),
        .flags    (flags),
        .dbg_sel  (dbg_sel),
        .dbg_data (dbg_data)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), 16'(dbg_data), 16'(mr[i]));
        end
    endtask

    function automatic logic [15:0] mk(input int op, input int rd, input int rs, input int imm);
        return {4'(op), 2'(rd), 2'(rs), 8'(imm)};
    endfunction

    // Architectural effect of one instruction on the model registers and flags
    task automatic predict(input logic [15:0] ins, output logic [7:0] res, output logic ill);
        logic [3:0]  op;
        logic [1:0]  rd, rs;
        logic [11:0] alu;
        op  = ins[15:12];
        rd  = ins[11:10];
        rs  = ins[9:8];
        alu = alu_model(op, mr[rd], mr[rs]);
        ill = (op > 4'd10);
        if (ill) begin
            res = 8'h00;
        end else if (op == 4'd10) begin
            res    = ins[7:0];
            mr[rd] = res;
        end else begin
            res    = alu[7:0];
            mr[rd] = res;
            if (op == 4'd2 || op == 4'd6) mflags = alu[11:8];
            else                          mflags[1:0] = alu[9:8];
        end
    endtask

    task automatic issue(input logic [15:0] ins, input string tag);
        logic [7:0] exp_a, exp_b, exp_res;
        logic       exp_ill;
        int         waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 8) begin
            @(negedge clk);
            waited++;
        end
        chk({tag, "_rdy_idle"}, 16'(in_ready), 16'(1));
        exp_a = mr[ins[11:10]];
        exp_b = mr[ins[9:8]];
        predict(ins, exp_res, exp_ill);
        in_valid = 1'b1;
        in_instr = ins;
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_rdy_dec"}, 16'(in_ready), 16'(0));
        chk({tag, "_alu_op"},  16'(alu_op), 16'(ins[15:12]));
        chk({tag, "_alu_a"},   16'(alu_a), 16'(exp_a));
        chk({tag, "_alu_b"},   16'(alu_b), 16'(exp_b));
        @(negedge clk);
        chk({tag, "_done_exec"}, 16'(done), 16'(0));
        @(negedge clk);
        chk({tag, "_done_wb"}, 16'(done), 16'(1));
        chk({tag, "_illegal"}, 16'(illegal), 16'(exp_ill));
        chk({tag, "_result"},  16'(result), 16'(exp_res));
        @(negedge clk);
        chk({tag, "_rdy_after"},  16'(in_ready), 16'(1));
        chk({tag, "_done_after"}, 16'(done), 16'(0));
        chk({tag, "_flags"},      16'(flags), 16'(mflags));
        check_regs(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of run, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        logic [15:0] ia, ib, ins;
        logic [7:0]  ra, rb;
        logic        la, lb;

        rst      = 1'b1;
        in_valid = 1'b0;
        in_instr = 16'h0000;
        dbg_sel  = 2'd0;
        for (int i = 0; i < 4; i++) mr[i] = 8'h00;
        mflags = 4'h0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_rdy",     16'(in_ready), 16'(0));
        chk("rst_done",    16'(done), 16'(0));
        chk("rst_illegal", 16'(illegal), 16'(0));
        chk("rst_result",  16'(result), 16'(0));
        chk("rst_flags",   16'(flags), 16'(0));
        chk("rst_alu_op",  16'(alu_op), 16'(0));
        chk("rst_alu_a",   16'(alu_a), 16'(0));
        chk("rst_alu_b",   16'(alu_b), 16'(0));
        rst = 1'b0;
        #1;
        chk("rst_rdy_release", 16'(in_ready), 16'(1));
        check_regs("rst");

        // LDI/LDI/ADD: 5 + 3
        issue(mk(10, 0, 0, 8'h05), "ldi_r0");
        issue(mk(10, 1, 0, 8'h03), "ldi_r1");
        issue(mk(2, 0, 1, 0), "add_5_3");
        chk("add_5_3_res_const",   16'(result), 16'h0008);
        chk("add_5_3_flags_const", 16'(flags), 16'h0);

        // Signed overflow into the sign bit, then self-subtract to zero
        issue(mk(10, 2, 0, 8'h7F), "ldi_r2");
        issue(mk(10, 3, 0, 8'h01), "ldi_r3");
        issue(mk(2, 2, 3, 0), "add_ovf");
        chk("add_ovf_res_const",   16'(result), 16'h0080);
        chk("add_ovf_flags_const", 16'(flags), 16'b0110);
        issue(mk(6, 2, 2, 0), "sub_self");
        chk("sub_self_res_const",   16'(result), 16'h0000);
        chk("sub_self_flags_const", 16'(flags), 16'b0001);

        // Shift keeps cr/ov from the preceding ADD
        issue(mk(10, 2, 0, 8'h7F), "ldi_r2b");
        issue(mk(2, 2, 3, 0), "add_ovf2");
        issue(mk(3, 2, 0, 0), "ls_80");
        chk("ls_80_res_const",   16'(result), 16'h0000);
        chk("ls_80_flags_const", 16'(flags), 16'b0101);

        // Undefined opcode: no write, flags held
        issue(mk(12, 1, 2, 8'hFF), "illegal_c");
        chk("illegal_c_flags_const", 16'(flags), 16'b0101);

        // in_valid held through busy with two different instructions
        ia = mk(2, 0, 0, 0);
        ib = mk(2, 1, 1, 0);
        @(negedge clk);
        chk("hold_rdy0", 16'(in_ready), 16'(1));
        predict(ia, ra, la);
        in_valid = 1'b1;
        in_instr = ia;
        @(negedge clk);
        chk("hold_rdy1", 16'(in_ready), 16'(0));
        in_instr = ib;
        @(negedge clk);
        chk("hold_rdy2", 16'(in_ready), 16'(0));
        @(negedge clk);
        chk("hold_rdy3",   16'(in_ready), 16'(0));
        chk("hold_done_a", 16'(done), 16'(1));
        chk("hold_res_a",  16'(result), 16'(ra));
        @(negedge clk);
        chk("hold_rdy4",     16'(in_ready), 16'(1));
        chk("hold_done_gap", 16'(done), 16'(0));
        predict(ib, rb, lb);
        @(negedge clk);
        chk("hold_rdy5", 16'(in_ready), 16'(0));
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("hold_done_b", 16'(done), 16'(1));
        chk("hold_res_b",  16'(result), 16'(rb));
        @(negedge clk);
        chk("hold_done_end", 16'(done), 16'(0));
        chk("hold_flags",    16'(flags), 16'(mflags));
        check_regs("hold");
        @(negedge clk);
        chk("hold_no_third", 16'(done), 16'(0));

        // Reset during EXEC of an ADD
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = mk(2, 0, 1, 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_done", 16'(done), 16'(0));
        chk("mid_rst_rdy",  16'(in_ready), 16'(0));
        rst = 1'b0;
        for (int i = 0; i < 4; i++) mr[i] = 8'h00;
        mflags = 4'h0;
        @(negedge clk);
        chk("mid_rst_rdy_after", 16'(in_ready), 16'(1));
        chk("mid_rst_done_after", 16'(done), 16'(0));
        chk("mid_rst_alu_op", 16'(alu_op), 16'(0));
        chk("mid_rst_flags",  16'(flags), 16'(0));
        check_regs("mid_rst");

        // Random instruction mix, LDI-biased so registers carry varied values
        for (int n = 0; n < 40; n++) begin
            ins = 16'($urandom);
            if (n % 3 == 0) ins[15:12] = 4'd10;
            else            ins[15:12] = 4'($urandom_range(0, 15));
            issue(ins, $sformatf("rnd%0d", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Sequencing control unit that drives the 8-bit ALU from the other side of its interface. Accepts 16-bit instructions over a valid/ready handshake, reads two operands from a 4×8 register file, and presents `alu_op`/`alu_a`/`alu_b` to the ALU. It then captures the ALU result and flags, writes the result back, and signals completion. It sits between the instruction source (fetch or testbench) and the combinational ALU.

## Interface
Parameters:
- `DW`, 8, datapath width (fixed to 8 for this design)
- `NREG`, 4, register count (address width 2)

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  instruction valid
- `in_ready`  out  1  unit can accept an instruction
- `in_instr`  in  16  `[15:12]` op, `[11:10]` rd, `[9:8]` rs, `[7:0]` imm
- `alu_op`  out  4  registered opcode to ALU
- `alu_a` / `alu_b`  out  8  registered operands: `R[rd]` and `R[rs]`
- `alu_y`  in  8  ALU result (combinational from `alu_*`)
- `alu_cr`, `alu_ov`, `alu_ng`, `alu_zr`  in  1  ALU flags
- `done`  out  1  one-cycle pulse when an instruction retires
- `result`  out  8  value written (valid with `done`)
- `illegal`  out  1  pulse with `done` for an undefined opcode
- `flags`  out  4  `{cr, ov, ng, zr}` status register
- `dbg_sel`  in  2 / `dbg_data`  out  8  combinational register-file read port

## Operation
- Opcodes: AND 0000, OR 0001, ADD 0010, LS 0011, SRS 0100, URS 0101, SUB 0110, SLT 0111, RRO 1000, LRO 1001, LDI 1010. Opcodes 1011–1111 are illegal.
- FSM states and transitions:
  - IDLE: `in_ready`=1. When `in_valid`&&`in_ready`, latch `in_instr` and go to DECODE.
  - DECODE: drive `alu_op`←op, `alu_a`←`R[rd]`, `alu_b`←`R[rs]` (registered). Go to EXEC.
  - EXEC: sample `alu_y` and the flags into internal holding registers. Go to WB.
  - WB: write `R[rd]` and assert `done`. Go to IDLE.
- LDI: writes imm to `R[rd]` and ignores `alu_y`. It still drives `alu_op`=LDI code and leaves `flags` unchanged.
- Flag update rules:
  - ADD/SUB update all four flags.
  - AND/OR/LS/SRS/URS/SLT/RRO/LRO update `ng`,`zr` only; `cr`,`ov` hold.
- Illegal op: no register write and `flags` hold. `result`=0x00, `done`=1 and `illegal`=1 in WB.
- Arithmetic is performed entirely by the ALU. This unit does no width extension; all values are 8-bit.
- `in_ready`=0 in DECODE/EXEC/WB. A `valid` held during busy is accepted exactly once, in the next IDLE.
- `rd`==`rs` is legal; both operands read the same register.
- Reset values: `in_ready`=0 during reset and 1 in the first cycle after it. `alu_op`=0000, `alu_a`=`alu_b`=0x00, `done`=0, `illegal`=0, `result`=0x00, `flags`=0000, all registers 0x00, state=IDLE.
- Reset mid-operation returns to IDLE with no `done` and no write-back.

## Timing
- Accept at edge T. DECODE occupies T+1, EXEC T+2, WB T+3: `done` is high during cycle T+3.
- The written register is visible on `dbg_data` from T+4.
- Throughput is one instruction per 4 cycles. The next accept is possible at T+4 (IDLE).
- `alu_*` outputs are stable from DECODE through WB. The ALU path gets one full cycle (EXEC) to settle.
- `done`/`illegal` are single-cycle pulses. `result` holds its last value until the next WB.

## Structure
- Shared package `alu_pkg`:
  - opcode localparams (shared with the ALU)
  - FSM state encodings (IDLE=0, DECODE=1, EXEC=2, WB=3)
  - instruction field bit positions
- Sub-module `alu_regfile`: 4×8, one synchronous write port, two combinational read ports plus the debug read port, synchronous clear on `rst`.
- Top level holds the FSM, operand/opcode registers, flag logic and the handshake.

## Test plan
- LDI R0←0x05, LDI R1←0x03, then ADD rd=0,rs=1 with a model ALU: `done` 3 cycles after accept, `result`=0x08, `R0`=0x08, `flags`=0000.
- LDI R2←0x7F, LDI R3←0x01, ADD rd=2,rs=3 → `R2`=0x80, `flags`={cr0,ov1,ng1,zr0}. Then SUB rd=2,rs=2 → 0x00, `zr`=1.
- After a flag-setting ADD, run LS on R2=0x80 → `result`=0x00, `zr`=1, `ng`=0, and `cr`/`ov` unchanged.
- Opcode 1100 → `illegal`=1 with `done`, `result`=0x00, all registers and `flags` unchanged.
- Hold `in_valid` high with two different instructions during busy → each accepted exactly once, `in_ready` pattern 1,0,0,0,1.
- Assert `rst` during EXEC of ADD → no `done`, registers all 0x00, `alu_op`=0000, `in_ready`=1 on the cycle after `rst` falls.
